// File: rtl/alpha_fade_sequencer.sv
// alpha_fade_sequencer: steps the sprite/background blend alpha once per video frame
//   to fade in, fade out, or fade in-hold-out.
// Latency: alpha moves on the frame_tick edge. done pulses in the cycle after the
//   tick that produced the terminal alpha.
// Backpressure: none. start is only sampled while busy=0. While busy, only abort
//   and frame_tick are honoured.
// Ports:
//   clk, reset     - clock, asynchronous active-high reset
//   frame_tick     - one-cycle pulse at start of vertical blanking
//   start/mode/step- transition request, mode select, alpha increment (0 acts as 1)
//   abort          - cancel an in-progress transition (no done pulse)
//   alpha          - registered blend alpha
//   sprite_en      - registered, high whenever alpha is non-zero
//   busy/done      - transition in progress / one-cycle normal completion pulse
module alpha_fade_sequencer #(
  parameter int HOLD_FRAMES = 60,
  parameter int HOLD_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic [7:0] step,
  input  logic       abort,
  output logic [7:0] alpha,
  output logic       sprite_en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UP   = 3'd1,
    HOLD = 3'd2,
    DOWN = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [7:0]        step_q;
  logic [1:0]        mode_q;

  // Saturating ramp arithmetic. The ninth bit catches overflow and underflow.
  logic [8:0]        up_sum;
  logic signed [8:0] dn_diff;
  logic [7:0]        up_val;
  logic [7:0]        dn_val;

  assign up_sum  = {1'b0, alpha} + {1'b0, step_q};
  assign dn_diff = $signed({1'b0, alpha}) - $signed({1'b0, step_q});
  assign up_val  = up_sum[8] ? 8'd255 : up_sum[7:0];
  assign dn_val  = (dn_diff < 0) ? 8'd0 : dn_diff[7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      alpha     <= 8'd0;
      sprite_en <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hold_cnt  <= '0;
      step_q    <= 8'd1;
      mode_q    <= 2'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // DONE lasts one cycle, but it can launch the next transition directly.
          done <= 1'b0;
          if (state == DONE) begin
            state <= IDLE;
          end
          if (start && !abort) begin
            step_q <= (step == 8'd0) ? 8'd1 : step;
            mode_q <= (mode == 2'd3) ? 2'd0 : mode;
            busy   <= 1'b1;
            if (mode == 2'd1) begin
              alpha     <= 8'd255;
              sprite_en <= 1'b1;
              state     <= DOWN;
            end else begin
              alpha     <= 8'd0;
              sprite_en <= 1'b0;
              state     <= UP;
            end
          end
        end

        UP: begin
          if (abort) begin
            state     <= IDLE;
            alpha     <= 8'd0;
            sprite_en <= 1'b0;
            busy      <= 1'b0;
          end else if (frame_tick) begin
            alpha     <= up_val;
            sprite_en <= (up_val != 8'd0);
            if (up_val == 8'd255) begin
              if (mode_q == 2'd2) begin
                if (HOLD_FRAMES > 0) begin
                  state    <= HOLD;
                  hold_cnt <= HOLD_W'(HOLD_FRAMES);
                end else begin
                  state <= DOWN;
                end
              end else begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
        end

        HOLD: begin
          if (abort) begin
            state     <= IDLE;
            alpha     <= 8'd0;
            sprite_en <= 1'b0;
            busy      <= 1'b0;
          end else if (frame_tick) begin
            // Alpha is not stepped on the tick that leaves HOLD.
            hold_cnt <= hold_cnt - HOLD_W'(1);
            if (hold_cnt == HOLD_W'(1)) begin
              state <= DOWN;
            end
          end
        end

        DOWN: begin
          if (abort) begin
            state     <= IDLE;
            alpha     <= 8'd0;
            sprite_en <= 1'b0;
            busy      <= 1'b0;
          end else if (frame_tick) begin
            alpha     <= dn_val;
            sprite_en <= (dn_val != 8'd0);
            if (dn_val == 8'd0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end

        default: begin
          state     <= IDLE;
          alpha     <= 8'd0;
          sprite_en <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alpha_fade_sequencer.sv
module tb_alpha_fade_sequencer;

  logic       clk;
  logic       reset;
  logic       frame_tick;
  logic       start;
  logic [1:0] mode;
  logic [7:0] step;
  logic       abort;
  logic [7:0] alpha;
  logic       sprite_en;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  alpha_fade_sequencer #(.HOLD_FRAMES(3), .HOLD_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .start      (start),
    .mode       (mode),
    .step       (step),
    .abort      (abort),
    .alpha      (alpha),
    .sprite_en  (sprite_en),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock, then settle 1 time unit past the edge before looking.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic launch(input logic [1:0] m, input logic [7:0] s);
    mode  = m;
    step  = s;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic cleanup();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1; frame_tick = 0; start = 0; mode = 0; step = 0; abort = 0;
    cyc(); cyc();
    checks++; if (alpha !== 8'd0)   begin errors++; $display("FAIL reset_alpha got=%0d exp=0", alpha); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (sprite_en !== 1'b0) begin errors++; $display("FAIL reset_sprite_en got=%b exp=0", sprite_en); end
    reset = 1'b0;
    cyc();
    // Mid-ramp reset: mode 0, step 16, five ticks -> alpha 80.
    launch(2'd0, 8'd16);
    for (int i = 0; i < 5; i++) do_tick();
    checks++; if (alpha !== 8'd80) begin errors++; $display("FAIL midramp_alpha got=%0d exp=80", alpha); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (alpha !== 8'd0 || busy !== 1'b0 || sprite_en !== 1'b0)
      begin errors++; $display("FAIL async_reset alpha=%0d busy=%b sprite_en=%b exp 0/0/0", alpha, busy, sprite_en); end
    cyc();
    reset = 1'b0;
    cyc();
    launch(2'd0, 8'd16);
    do_tick();
    checks++; if (alpha !== 8'd16 || busy !== 1'b1)
      begin errors++; $display("FAIL post_reset_start alpha=%0d busy=%b exp 16/1", alpha, busy); end
    cleanup();
  endtask

  task automatic test_fade_in();
    int e;
    launch(2'd0, 8'd4);
    checks++; if (alpha !== 8'd0 || busy !== 1'b1)
      begin errors++; $display("FAIL fadein_accept alpha=%0d busy=%b exp 0/1", alpha, busy); end
    for (int i = 1; i <= 64; i++) begin
      do_tick();
      e = (4 * i > 255) ? 255 : 4 * i;
      checks++; if (alpha !== 8'(e)) begin errors++; $display("FAIL fadein_alpha tick=%0d got=%0d exp=%0d", i, alpha, e); end
      checks++; if (sprite_en !== 1'b1) begin errors++; $display("FAIL fadein_sprite_en tick=%0d got=%b exp=1", i, sprite_en); end
      if (i < 64) begin
        checks++; if (busy !== 1'b1 || done !== 1'b0)
          begin errors++; $display("FAIL fadein_busy tick=%0d busy=%b done=%b exp 1/0", i, busy, done); end
      end
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL fadein_done done=%b busy=%b exp 1/0", done, busy); end
    cyc();
    checks++; if (done !== 1'b0 || alpha !== 8'd255)
      begin errors++; $display("FAIL fadein_after done=%b alpha=%0d exp 0/255", done, alpha); end
  endtask

  task automatic test_fade_out_step0();
    int pulses = 0;
    launch(2'd1, 8'd0);
    checks++; if (alpha !== 8'd255 || sprite_en !== 1'b1 || busy !== 1'b1)
      begin errors++; $display("FAIL fadeout_accept alpha=%0d sprite_en=%b busy=%b exp 255/1/1", alpha, sprite_en, busy); end
    for (int i = 1; i <= 255; i++) begin
      do_tick();
      if (done === 1'b1) pulses++;
      checks++; if (alpha !== 8'(255 - i)) begin errors++; $display("FAIL fadeout_alpha tick=%0d got=%0d exp=%0d", i, alpha, 255 - i); end
    end
    checks++; if (sprite_en !== 1'b0 || done !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL fadeout_end sprite_en=%b done=%b busy=%b exp 0/1/0", sprite_en, done, busy); end
    cyc();
    if (done === 1'b1) pulses++;
    checks++; if (pulses !== 1) begin errors++; $display("FAIL fadeout_done_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_in_hold_out();
    logic [7:0] exp_seq [7];
    exp_seq = '{8'd128, 8'd255, 8'd255, 8'd255, 8'd255, 8'd127, 8'd0};
    launch(2'd2, 8'd128);
    for (int i = 0; i < 7; i++) begin
      do_tick();
      checks++; if (alpha !== exp_seq[i]) begin errors++; $display("FAIL hold_alpha tick=%0d got=%0d exp=%0d", i + 1, alpha, exp_seq[i]); end
      if (i < 6) begin
        checks++; if (busy !== 1'b1 || done !== 1'b0)
          begin errors++; $display("FAIL hold_busy tick=%0d busy=%b done=%b exp 1/0", i + 1, busy, done); end
      end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL hold_done got=%b exp=1", done); end
    cyc();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL hold_done_once got=%b exp=0", done); end
  endtask

  task automatic test_abort();
    int pulses = 0;
    launch(2'd0, 8'd8);
    for (int i = 0; i < 9; i++) do_tick();
    checks++; if (alpha !== 8'd72) begin errors++; $display("FAIL abort_pre alpha=%0d exp=72", alpha); end
    abort = 1'b1; frame_tick = 1'b1;
    cyc();
    abort = 1'b0; frame_tick = 1'b0;
    if (done === 1'b1) pulses++;
    checks++; if (alpha !== 8'd0 || busy !== 1'b0 || sprite_en !== 1'b0)
      begin errors++; $display("FAIL abort_state alpha=%0d busy=%b sprite_en=%b exp 0/0/0", alpha, busy, sprite_en); end
    for (int i = 0; i < 3; i++) begin cyc(); if (done === 1'b1) pulses++; end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", pulses); end
    // start and abort together while idle: ignored
    abort = 1'b1;
    launch(2'd1, 8'd5);
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || alpha !== 8'd0)
      begin errors++; $display("FAIL start_abort_idle busy=%b alpha=%0d exp 0/0", busy, alpha); end
    // start while busy must not alter latched mode/step
    launch(2'd0, 8'd8);
    do_tick();
    launch(2'd1, 8'd100);
    do_tick();
    checks++; if (alpha !== 8'd16 || busy !== 1'b1)
      begin errors++; $display("FAIL start_while_busy alpha=%0d busy=%b exp 16/1", alpha, busy); end
    cleanup();
  endtask

  task automatic test_back_to_back();
    launch(2'd0, 8'd128);
    do_tick();
    do_tick();
    checks++; if (alpha !== 8'd255 || done !== 1'b1)
      begin errors++; $display("FAIL b2b_first alpha=%0d done=%b exp 255/1", alpha, done); end
    launch(2'd1, 8'd85);
    checks++; if (busy !== 1'b1 || done !== 1'b0 || alpha !== 8'd255)
      begin errors++; $display("FAIL b2b_accept busy=%b done=%b alpha=%0d exp 1/0/255", busy, done, alpha); end
    do_tick(); do_tick();
    checks++; if (alpha !== 8'd85) begin errors++; $display("FAIL b2b_down alpha=%0d exp=85", alpha); end
    do_tick();
    checks++; if (alpha !== 8'd0 || done !== 1'b1)
      begin errors++; $display("FAIL b2b_end alpha=%0d done=%b exp 0/1", alpha, done); end
    cyc();
    // start coincident with frame_tick: no step on the accepting edge
    frame_tick = 1'b1;
    launch(2'd0, 8'd50);
    frame_tick = 1'b0;
    checks++; if (alpha !== 8'd0 || busy !== 1'b1)
      begin errors++; $display("FAIL coincide_accept alpha=%0d busy=%b exp 0/1", alpha, busy); end
    cyc();
    checks++; if (alpha !== 8'd0) begin errors++; $display("FAIL coincide_hold alpha=%0d exp=0", alpha); end
    do_tick();
    checks++; if (alpha !== 8'd50) begin errors++; $display("FAIL coincide_step alpha=%0d exp=50", alpha); end
    cleanup();
    // reserved mode 3 behaves as fade-in; step 255 saturates in one tick
    launch(2'd3, 8'd255);
    do_tick();
    checks++; if (alpha !== 8'd255 || done !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL mode3 alpha=%0d done=%b busy=%b exp 255/1/0", alpha, done, busy); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_fade_in();
    test_fade_out_step0();
    test_in_hold_out();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
